// File: rtl/cnn_ctrl_pkg.sv
// Shared encodings for the CNN control slice: per-buffer states, the
// ping-pong top FSM states and the A/B buffer select values.
package cnn_ctrl_pkg;

   typedef enum logic [1:0] {
      BUF_FREE    = 2'd0,
      BUF_LOADING = 2'd1,
      BUF_READY   = 2'd2,
      BUF_BUSY    = 2'd3
   } buf_state_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } top_state_t;

   localparam logic BUF_A = 1'b0;
   localparam logic BUF_B = 1'b1;

endpackage

// File: rtl/pp_buf_tracker.sv
// Lifecycle of one input tile buffer: FREE -> LOADING -> READY -> BUSY -> FREE.
// Each strobe only advances the buffer out of the state it applies to.
module pp_buf_tracker
   import cnn_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       load_start,
   input  logic       load_done,
   input  logic       comp_start,
   input  logic       comp_done,
   output buf_state_t buf_state
);

   buf_state_t buf_state_nxt;

   always_comb begin
      buf_state_nxt = buf_state;
      if (clr) begin
         buf_state_nxt = BUF_FREE;
      end else begin
         case (buf_state)
            BUF_FREE:    if (load_start) buf_state_nxt = BUF_LOADING;
            BUF_LOADING: if (load_done)  buf_state_nxt = BUF_READY;
            BUF_READY:   if (comp_start) buf_state_nxt = BUF_BUSY;
            BUF_BUSY:    if (comp_done)  buf_state_nxt = BUF_FREE;
            default:                     buf_state_nxt = BUF_FREE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) buf_state <= BUF_FREE;
      else       buf_state <= buf_state_nxt;
   end

endmodule

// File: rtl/input_pingpong_ctrl.sv
// Ping-pong sequencer for the A/B input tile buffers: the DMA bridge fills one
// buffer while the conv engine computes on the other.
module input_pingpong_ctrl
   import cnn_ctrl_pkg::*;
#(
   parameter int TILE_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_start,
   input  logic [TILE_W-1:0] cfg_num_tiles,
   output logic              dma_req,
   input  logic              dma_done,
   output logic              active_in_buf,
   output logic              compute_start,
   output logic              compute_buf,
   input  logic              compute_done,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [TILE_W-1:0] tiles_done
);

   top_state_t        state, state_nxt;
   buf_state_t        buf_a, buf_b;
   buf_state_t        fill_st, comp_st;
   logic              fill_sel, comp_sel;
   logic [TILE_W-1:0] num_tiles, issued;
   logic              run, any_loading, any_busy;
   logic              start_any, start_run, start_empty;
   logic              dma_ok, comp_ok, last_tile, proto_err;

   assign run         = (state == ST_RUN);
   assign fill_st     = fill_sel ? buf_b : buf_a;
   assign comp_st     = comp_sel ? buf_b : buf_a;
   assign any_loading = (buf_a == BUF_LOADING) || (buf_b == BUF_LOADING);
   assign any_busy    = (buf_a == BUF_BUSY) || (buf_b == BUF_BUSY);
   assign start_any   = !run && cfg_start;
   assign start_run   = start_any && (cfg_num_tiles != '0);
   assign start_empty = start_any && (cfg_num_tiles == '0);
   // fill_sel is frozen while loading, so the LOADING buffer is always fill_sel
   assign dma_ok      = run && dma_done && any_loading;
   assign comp_ok     = run && compute_done && any_busy;
   assign last_tile   = comp_ok && ((tiles_done + TILE_W'(1)) == num_tiles);

   assign busy          = run;
   assign active_in_buf = fill_sel;
   assign compute_buf   = comp_sel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      dma_req       = 1'b0;
      compute_start = 1'b0;
      proto_err     = 1'b0;
      case (state)
         ST_IDLE: begin
            proto_err = dma_done || compute_done;
            if (start_run) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            dma_req       = (fill_st == BUF_FREE) && (issued < num_tiles) && !any_loading;
            compute_start = (comp_st == BUF_READY) && !any_busy;
            proto_err     = (dma_done && !any_loading) || (compute_done && !any_busy);
            if (last_tile) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill_sel   <= BUF_A;
         comp_sel   <= BUF_A;
         num_tiles  <= '0;
         issued     <= '0;
         tiles_done <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= start_empty || last_tile;
         // a protocol error in the same cycle as a start still sticks
         if (start_any) begin
            err        <= proto_err;
            tiles_done <= '0;
            fill_sel   <= BUF_A;
            comp_sel   <= BUF_A;
         end else begin
            err <= err || proto_err;
         end
         if (start_run) begin
            num_tiles <= cfg_num_tiles;
            issued    <= '0;
         end
         if (dma_req) issued <= issued + TILE_W'(1);
         if (dma_ok)  fill_sel <= ~fill_sel;
         if (comp_ok) begin
            comp_sel   <= ~comp_sel;
            tiles_done <= tiles_done + TILE_W'(1);
         end
      end
   end

   pp_buf_tracker u_buf_a (
      .clk        (clk),
      .reset      (reset),
      .clr        (start_run),
      .load_start (dma_req && (fill_sel == BUF_A)),
      .load_done  (dma_ok && (fill_sel == BUF_A)),
      .comp_start (compute_start && (comp_sel == BUF_A)),
      .comp_done  (comp_ok && (comp_sel == BUF_A)),
      .buf_state  (buf_a)
   );

   pp_buf_tracker u_buf_b (
      .clk        (clk),
      .reset      (reset),
      .clr        (start_run),
      .load_start (dma_req && (fill_sel == BUF_B)),
      .load_done  (dma_ok && (fill_sel == BUF_B)),
      .comp_start (compute_start && (comp_sel == BUF_B)),
      .comp_done  (comp_ok && (comp_sel == BUF_B)),
      .buf_state  (buf_b)
   );

endmodule

// File: tb/tb_input_pingpong_ctrl.sv
// Directed bench for input_pingpong_ctrl: cycle-exact checks in one initial
// block plus a scoreboard that matches every dma_req/compute_start/done pulse.
module tb_input_pingpong_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cfg_start;
   logic [15:0] cfg_num_tiles;
   logic        dma_req;
   logic        dma_done;
   logic        active_in_buf;
   logic        compute_start;
   logic        compute_buf;
   logic        compute_done;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] tiles_done;

   int errors = 0;
   int checks = 0;
   int dma_cnt = 0;
   int cs_cnt = 0;
   int d0, c0;

   logic        dma_q  [$];
   logic        cs_q   [$];
   logic [15:0] done_q [$];

   input_pingpong_ctrl #(.TILE_W(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .cfg_start     (cfg_start),
      .cfg_num_tiles (cfg_num_tiles),
      .dma_req       (dma_req),
      .dma_done      (dma_done),
      .active_in_buf (active_in_buf),
      .compute_start (compute_start),
      .compute_buf   (compute_buf),
      .compute_done  (compute_done),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .tiles_done    (tiles_done)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs just after the edge, then stop at the falling edge.
   task automatic apply_stimulus(input logic cs, input logic [15:0] nt, input logic dd, input logic cd);
      @(posedge clk);
      #1;
      cfg_start     = cs;
      cfg_num_tiles = nt;
      dma_done      = dd;
      compute_done  = cd;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
   endtask

   // Scoreboard: every pulse must have been predicted, with the right buffer/count.
   always @(negedge clk) begin
      if (dma_req) begin
         dma_cnt++;
         check_output("dma_req_predicted", dma_q.size() != 0, 1);
         if (dma_q.size() != 0) check_output("dma_active_buf", active_in_buf, dma_q.pop_front());
      end
      if (compute_start) begin
         cs_cnt++;
         check_output("cs_predicted", cs_q.size() != 0, 1);
         if (cs_q.size() != 0) check_output("cs_compute_buf", compute_buf, cs_q.pop_front());
      end
      if (done) begin
         check_output("done_predicted", done_q.size() != 0, 1);
         if (done_q.size() != 0) check_output("done_tiles", tiles_done, done_q.pop_front());
      end
   end

   initial begin
      reset = 1'b1;
      cfg_start = 1'b0;
      cfg_num_tiles = '0;
      dma_done = 1'b0;
      compute_done = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_output("rst_busy", busy, 0);
      check_output("rst_done", done, 0);
      check_output("rst_err", err, 0);
      check_output("rst_dma_req", dma_req, 0);
      check_output("rst_active", active_in_buf, 0);
      check_output("rst_compute_buf", compute_buf, 0);
      check_output("rst_tiles", tiles_done, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      $display("[TB] stray dma_done in IDLE, then empty run clears err");
      apply_stimulus(1'b0, 16'd0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("stray_err_set", err, 1);
      check_output("stray_busy", busy, 0);
      done_q.push_back(16'd0);
      apply_stimulus(1'b1, 16'd0, 1'b0, 1'b0);
      check_output("n0_busy_t", busy, 0);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("n0_done", done, 1);
      check_output("n0_busy", busy, 0);
      check_output("n0_err_cleared", err, 0);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("n0_done_pulse", done, 0);
      check_output("n0_no_dma", dma_cnt, 0);
      check_output("n0_no_cs", cs_cnt, 0);

      $display("[TB] stray compute_done, then single tile");
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("stray_cd_err", err, 1);
      dma_q.push_back(1'b0);
      cs_q.push_back(1'b0);
      done_q.push_back(16'd1);
      apply_stimulus(1'b1, 16'd1, 1'b0, 1'b0);
      check_output("n1_dma_t", dma_req, 0);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("n1_dma_t1", dma_req, 1);
      check_output("n1_busy", busy, 1);
      check_output("n1_err_cleared", err, 0);
      idle(8);
      apply_stimulus(1'b0, 16'd0, 1'b1, 1'b0);
      check_output("n1_cs_early", compute_start, 0);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("n1_cs_t11", compute_start, 1);
      idle(18);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b1);
      check_output("n1_done_early", done, 0);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("n1_done", done, 1);
      check_output("n1_tiles", tiles_done, 1);
      check_output("n1_busy_drop", busy, 0);
      check_output("n1_err", err, 0);

      $display("[TB] four tiles back-to-back with overlapping done strobes");
      d0 = dma_cnt;
      c0 = cs_cnt;
      dma_q.push_back(1'b0); dma_q.push_back(1'b1); dma_q.push_back(1'b0); dma_q.push_back(1'b1);
      cs_q.push_back(1'b0);  cs_q.push_back(1'b1);  cs_q.push_back(1'b0);  cs_q.push_back(1'b1);
      done_q.push_back(16'd4);
      apply_stimulus(1'b1, 16'd4, 1'b0, 1'b0);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("n4_req1", dma_req, 1);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("n4_hold_while_loading", dma_req, 0);
      apply_stimulus(1'b0, 16'd0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("n4_req2", dma_req, 1);
      check_output("n4_req2_buf", active_in_buf, 1);
      check_output("n4_cs1", compute_start, 1);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("n4_quiet", {dma_req, compute_start}, 0);
      apply_stimulus(1'b0, 16'd0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("n4_sim_cs", compute_start, 1);
      check_output("n4_sim_dma", dma_req, 1);
      check_output("n4_sim_err", err, 0);
      check_output("n4_tiles1", tiles_done, 1);
      idle(1);
      apply_stimulus(1'b0, 16'd0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("n4_sim2", {dma_req, compute_start}, 2'b11);
      check_output("n4_tiles2", tiles_done, 2);
      idle(1);
      apply_stimulus(1'b0, 16'd0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("n4_no_fifth_req", dma_req, 0);
      check_output("n4_cs4", compute_start, 1);
      idle(1);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("n4_done", done, 1);
      check_output("n4_tiles", tiles_done, 4);
      check_output("n4_busy_drop", busy, 0);
      check_output("n4_dma_count", dma_cnt - d0, 4);
      check_output("n4_cs_count", cs_cnt - c0, 4);
      check_output("n4_err", err, 0);

      $display("[TB] slow compute, three tiles");
      dma_q.push_back(1'b0); dma_q.push_back(1'b1); dma_q.push_back(1'b0);
      cs_q.push_back(1'b0);  cs_q.push_back(1'b1);  cs_q.push_back(1'b0);
      done_q.push_back(16'd3);
      apply_stimulus(1'b1, 16'd3, 1'b0, 1'b0);
      idle(2);
      apply_stimulus(1'b0, 16'd0, 1'b1, 1'b0);
      idle(2);
      apply_stimulus(1'b0, 16'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
         check_output("slow_no_third_req", dma_req, 0);
      end
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("slow_third_req", dma_req, 1);
      check_output("slow_third_buf", active_in_buf, 0);
      check_output("slow_cs_b", compute_start, 1);
      idle(1);
      apply_stimulus(1'b0, 16'd0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("slow_cs3", compute_start, 1);
      idle(1);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b1);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("slow_done", done, 1);
      check_output("slow_tiles", tiles_done, 3);

      $display("[TB] reset mid-run while A is loading");
      dma_q.push_back(1'b0);
      apply_stimulus(1'b1, 16'd2, 1'b0, 1'b0);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      check_output("mr_req", dma_req, 1);
      apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
      #1 reset = 1'b1;
      #1;
      check_output("mr_busy", busy, 0);
      check_output("mr_outputs", {dma_req, compute_start, done, err, active_in_buf, compute_buf}, 0);
      check_output("mr_tiles", tiles_done, 0);
      idle(2);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0);
         check_output("mr_idle", {busy, dma_req, done}, 0);
      end

      check_output("q_dma_empty", dma_q.size(), 0);
      check_output("q_cs_empty", cs_q.size(), 0);
      check_output("q_done_empty", done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/input_pingpong_ctrl.md
Name: input_pingpong_ctrl

Overview:
- Sequences the two input tile buffers (A/B) shared by the DMA input bridge and the compute engine.
- Decides which buffer the bridge fills (active_in_buf) and which buffer compute reads (compute_buf).
- Issues per-tile DMA requests and compute starts, so that loading tile N+1 overlaps computing tile N.
- Sits between the control unit/CSR block, the DMA input bridge and the conv engine.

Parameters:
TILE_W, 16, width of tile counters and the configured tile count

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
cfg_start  input  1  one-cycle pulse; latches cfg_num_tiles and begins a run
cfg_num_tiles  input  TILE_W  number of tiles in the run
dma_req  output  1  one-cycle pulse; request DMA MM2S transfer of next tile
dma_done  input  1  one-cycle pulse from bridge; tile fully written (tlast seen)
active_in_buf  output  1  fill target for bridge: 0 = A, 1 = B
compute_start  output  1  one-cycle pulse; compute may begin on compute_buf
compute_buf  output  1  buffer compute reads: 0 = A, 1 = B
compute_done  input  1  one-cycle pulse; compute finished with compute_buf
busy  output  1  high from the cycle after an accepted cfg_start until done
done  output  1  one-cycle pulse; all tiles computed
err  output  1  sticky protocol error; cleared by reset or an accepted cfg_start
tiles_done  output  TILE_W  tiles computed in the current run

Behaviour:
- Reset (async): all outputs 0. Both buffer states FREE. fill_sel = comp_sel = 0. Top state IDLE.
- Per-buffer state, 2 bits: FREE, LOADING, READY, BUSY.
- Top FSM, IDLE:
  - cfg_start with cfg_num_tiles = 0 -> done pulses next cycle; busy stays 0; no dma_req.
  - cfg_start with cfg_num_tiles != 0 -> RUN: latch count; clear issued/loaded/done counters and err; both buffers FREE; fill_sel = comp_sel = 0.
- Top FSM, RUN:
  - cfg_start is ignored.
  - Fill side: when buf[fill_sel] is FREE and issued < num_tiles and no buffer is LOADING -> dma_req pulses; buf[fill_sel] becomes LOADING; issued++.
  - First dma_req is asserted the cycle after the cfg_start edge.
  - active_in_buf = fill_sel, registered. It holds constant while any buffer is LOADING.
  - dma_done while a buffer is LOADING -> that buffer becomes READY and fill_sel toggles, effective next cycle.
- Compute side: when buf[comp_sel] is READY and no buffer is BUSY -> compute_start pulses; compute_buf = comp_sel; buffer becomes BUSY.
  - compute_start fires at the earliest one cycle after the dma_done that made the buffer READY.
  - compute_done while BUSY -> buffer becomes FREE; comp_sel toggles; tiles_done++.
  - If tiles_done reaches num_tiles -> done pulses the same cycle the count updates; FSM returns to IDLE; busy drops.
- Simultaneous dma_done and compute_done refer to different buffers. Both are applied in the same cycle.
- A buffer freed by compute_done is refillable the following cycle, so dma_req can pulse one cycle after compute_done.
- Protocol errors set err and are otherwise ignored; no state change:
  - dma_done with no LOADING buffer.
  - compute_done with no BUSY buffer.
  - Any dma_done or compute_done pulse in IDLE.
- Steady state: at most one LOADING and one BUSY buffer at any time; never both buffers BUSY.
- Counters are TILE_W bits and do not wrap, since issued ≤ num_tiles.
- Reset mid-run returns to the reset state immediately. No done pulse.

Decomposition:
- Shared package (cnn_ctrl_pkg):
  - Buffer-state encodings: BUF_FREE=0, BUF_LOADING=1, BUF_READY=2, BUF_BUSY=3.
  - Top-state encodings: ST_IDLE, ST_RUN.
  - Buffer select constants: BUF_A=0, BUF_B=1.
- One natural sub-module: pp_buf_tracker. It holds the state of a single buffer and takes load_start, load_done, comp_start and comp_done strobes. It is instantiated twice.

Test Plan:
- cfg_num_tiles=0, cfg_start -> done pulse next cycle; dma_req, compute_start and busy never assert.
- cfg_num_tiles=1: dma_req @t+1, active_in_buf=0; dma_done @t+10 -> compute_start @t+11 with compute_buf=0; compute_done @t+30 -> done=1, tiles_done=1, busy=0 same cycle.
- cfg_num_tiles=4, back-to-back:
  - Second dma_req goes out the cycle after the first dma_done, with active_in_buf=1.
  - compute_buf sequence is 0,1,0,1.
  - tiles_done ends at 4; exactly 4 dma_req and 4 compute_start pulses.
- Slow compute, num_tiles=3: dma_done for both A and B before the first compute_done -> no third dma_req until compute_done frees A; the third dma_req follows one cycle later with active_in_buf=0.
- Same-cycle dma_done (B) and compute_done (A) -> B becomes READY and A becomes FREE. compute_start on B and dma_req on A both pulse the next cycle; err stays 0.
- Stray dma_done in IDLE -> err=1, no state change. cfg_start then clears err.
- Separate case: reset asserted mid-run with A LOADING -> all outputs 0 and state IDLE; no done pulse.
